// File: rtl/mest_pro_pkg.sv
// Shared types and constants for the program sequencer: FSM encoding, opcode
// values, instruction field positions and default widths.
package mest_pro_pkg;

  localparam int OPC_W_DEF     = 4;
  localparam int DATA_W        = 8;
  localparam int INSTR_W_DEF   = OPC_W_DEF + 3 * DATA_W;
  localparam int ROM_DEPTH_DEF = 65536;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_HALT = 4'hF;

  // Instruction word: {opcode, operand A, operand B, tag}
  localparam int A_LSB   = 16;
  localparam int B_LSB   = 8;
  localparam int TAG_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_ALU  = 3'd4,
    S_WRITEBACK = 3'd5,
    S_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/mest_pro_sequencer.sv
// Walks a program ROM from address 0, issuing each instruction to an external
// ALU and reporting its result, until HALT or the last ROM word.
module mest_pro_sequencer
  import mest_pro_pkg::*;
#(
  parameter int OP_CODE_SIZE     = OPC_W_DEF,
  parameter int INSTRUCTION_SIZE = OP_CODE_SIZE + 3 * DATA_W,
  parameter int ROM_DEPTH        = ROM_DEPTH_DEF,
  localparam int ADDR_W          = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  output logic [ADDR_W-1:0]           o_rom_addr,
  output logic                        o_rom_rd_en,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic [OP_CODE_SIZE-1:0]     o_alu_op,
  output logic [DATA_W-1:0]           o_alu_a,
  output logic [DATA_W-1:0]           o_alu_b,
  output logic                        o_alu_valid,
  input  logic [DATA_W-1:0]           i_alu_result,
  input  logic                        i_alu_carry,
  input  logic                        i_alu_zero,
  input  logic                        i_alu_done,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_valid_result,
  output logic                        o_all_done,
  output logic                        o_busy
);

  state_e                      state_q;
  logic [ADDR_W-1:0]           pc_q;
  logic [INSTRUCTION_SIZE-1:0] ir_q;
  logic                        rd_en_q;
  logic                        alu_valid_q;
  logic [DATA_W-1:0]           result_q;
  logic                        carry_q;
  logic                        zero_q;
  logic                        vres_q;
  logic                        all_done_q;
  logic                        busy_q;

  logic [OP_CODE_SIZE-1:0] rom_op;
  logic                    rom_halt;
  logic                    rom_nop;
  logic                    pc_last;
  logic                    advance;
  logic [ADDR_W-1:0]       pc_inc_d;
  logic [DATA_W-1:0]       ir_tag_unused;

  assign rom_op   = i_rom_data[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
  assign rom_halt = (rom_op == OP_CODE_SIZE'(OPC_HALT));
  assign rom_nop  = (rom_op == OP_CODE_SIZE'(OPC_NOP));
  assign pc_last  = (pc_q == ADDR_W'(ROM_DEPTH - 1));
  assign pc_inc_d = pc_q + ADDR_W'(1);

  // NOPs and completed writebacks share the same PC step; the last ROM word
  // ends the program instead of wrapping back to address 0.
  assign advance = ((state_q == S_WAIT_ROM) && !rom_halt && rom_nop) ||
                   (state_q == S_WRITEBACK);

  assign ir_tag_unused = ir_q[TAG_LSB +: DATA_W];

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      rd_en_q     <= 1'b0;
      alu_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      vres_q      <= 1'b0;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rd_en_q     <= 1'b0;
      alu_valid_q <= 1'b0;
      vres_q      <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            all_done_q <= 1'b0;
          end
        end

        S_FETCH: state_q <= S_WAIT_ROM;

        S_WAIT_ROM: begin
          ir_q <= i_rom_data;
          if (rom_halt) begin
            state_q    <= S_DONE;
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (!rom_nop) begin
            state_q     <= S_ISSUE;
            alu_valid_q <= 1'b1;
          end
        end

        S_ISSUE: state_q <= S_WAIT_ALU;

        S_WAIT_ALU: begin
          if (i_alu_done) begin
            state_q  <= S_WRITEBACK;
            result_q <= i_alu_result;
            carry_q  <= i_alu_carry;
            zero_q   <= i_alu_zero;
            vres_q   <= 1'b1;
          end
        end

        S_WRITEBACK: ;

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (advance) begin
        if (pc_last) begin
          state_q    <= S_DONE;
          all_done_q <= 1'b1;
          busy_q     <= 1'b0;
        end else begin
          state_q <= S_FETCH;
          pc_q    <= pc_inc_d;
          rd_en_q <= 1'b1;
        end
      end
    end
  end

  assign o_rom_addr     = pc_q;
  assign o_rom_rd_en    = rd_en_q;
  assign o_alu_op       = ir_q[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
  assign o_alu_a        = ir_q[A_LSB +: DATA_W];
  assign o_alu_b        = ir_q[B_LSB +: DATA_W];
  assign o_alu_valid    = alu_valid_q;
  assign o_result       = result_q;
  assign o_carry        = carry_q;
  assign o_zero_flag    = zero_q;
  assign o_valid_result = vres_q;
  assign o_all_done     = all_done_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// Randomized bench: a ROM array, a variable-latency ALU stub and a program-level
// model that walks the ROM to predict fetches, issues and results.
module tb_mest_pro_sequencer;
  localparam int OCS   = 4;
  localparam int IS    = 28;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          i_reset, i_start;
  logic [AW-1:0] o_rom_addr;
  logic          o_rom_rd_en;
  logic [IS-1:0] i_rom_data;
  logic [OCS-1:0] o_alu_op;
  logic [7:0]    o_alu_a, o_alu_b;
  logic          o_alu_valid;
  logic [7:0]    i_alu_result;
  logic          i_alu_carry, i_alu_zero, i_alu_done;
  logic [7:0]    o_result;
  logic          o_carry, o_zero_flag, o_valid_result, o_all_done, o_busy;

  mest_pro_sequencer #(.OP_CODE_SIZE(OCS), .INSTRUCTION_SIZE(IS), .ROM_DEPTH(DEPTH)) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_rom_addr(o_rom_addr), .o_rom_rd_en(o_rom_rd_en), .i_rom_data(i_rom_data),
    .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_valid(o_alu_valid),
    .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry), .i_alu_zero(i_alu_zero),
    .i_alu_done(i_alu_done),
    .o_result(o_result), .o_carry(o_carry), .o_zero_flag(o_zero_flag),
    .o_valid_result(o_valid_result), .o_all_done(o_all_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ALU behaviour: {zero, carry, result}
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      4'h1:    s = {1'b0, a} + {1'b0, b};
      4'h2:    s = {(a < b), a - b};
      4'h3:    s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return {(s[7:0] == 8'd0), s[8], s[7:0]};
  endfunction

  logic [IS-1:0] rom [DEPTH];
  always @(posedge clk) if (o_rom_rd_en) i_rom_data <= rom[o_rom_addr];

  // Monitor + ALU stub, all on the falling edge
  logic [9:0] obs_res[$];
  int         obs_fetch[$];
  int         n_issue = 0, excl_viol = 0, lat_viol = 0;
  bit         pend = 0, real_prev = 0;
  int         cnt = 0;
  logic [9:0] pend_res;
  bit         hold_alu = 0, force_done = 0, spur_en = 0;

  always @(negedge clk) begin
    if (o_alu_valid && o_rom_rd_en) excl_viol++;
    if (o_valid_result != real_prev) lat_viol++;
    if (o_valid_result) obs_res.push_back({o_zero_flag, o_carry, o_result});
    if (o_rom_rd_en) obs_fetch.push_back(int'(o_rom_addr));
    if (o_alu_valid) n_issue++;
    real_prev  = 0;
    i_alu_done = 0;
    if (i_reset) begin
      pend = 0;
    end else if (o_alu_valid && !pend) begin
      pend = 1;
      cnt = $urandom_range(0, 3);
      pend_res = alu_fn(o_alu_op, o_alu_a, o_alu_b);
    end else if (pend && !hold_alu) begin
      if (cnt == 0) begin
        {i_alu_zero, i_alu_carry, i_alu_result} = pend_res;
        i_alu_done = 1;
        pend = 0;
        real_prev = 1;
      end else cnt--;
    end else if (force_done) begin
      {i_alu_zero, i_alu_carry, i_alu_result} = 10'h3AA;
      i_alu_done = 1;
    end else if (!pend && spur_en && $urandom_range(0, 5) == 0) begin
      {i_alu_zero, i_alu_carry, i_alu_result} = 10'($urandom);
      i_alu_done = 1;
    end
  end

  task automatic run_prog(input string nm, input bit busy_starts);
    logic [9:0] er[$];
    int ef[$];
    int ei = 0, pc = 0, cyc = 0;
    int r0, f0, i0, x0, l0;
    logic [3:0] op;
    forever begin
      ef.push_back(pc);
      op = rom[pc][27:24];
      if (op == 4'hF) break;
      if (op != 4'h0) begin
        er.push_back(alu_fn(op, rom[pc][23:16], rom[pc][15:8]));
        ei++;
      end
      if (pc == DEPTH - 1) break;
      pc++;
    end
    r0 = obs_res.size(); f0 = obs_fetch.size(); i0 = n_issue; x0 = excl_viol; l0 = lat_viol;
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    chk({nm, "_start_lat"}, {31'd0, o_rom_rd_en}, 32'd1);
    chk({nm, "_start_addr"}, 32'(o_rom_addr), 32'd0);
    chk({nm, "_done_low"}, {31'd0, o_all_done}, 32'd0);
    while (!o_all_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      i_start = (busy_starts && o_busy && $urandom_range(0, 7) == 0);
    end
    i_start = 0;
    chk({nm, "_all_done"}, {31'd0, o_all_done}, 32'd1);
    repeat (2) @(negedge clk);
    chk({nm, "_done_held"}, {30'd0, o_all_done, o_busy}, 32'd2);
    chk({nm, "_nres"}, obs_res.size() - r0, er.size());
    for (int i = 0; i < er.size() && r0 + i < obs_res.size(); i++)
      chk($sformatf("%s_res%0d", nm, i), 32'(obs_res[r0 + i]), 32'(er[i]));
    chk({nm, "_nfetch"}, obs_fetch.size() - f0, ef.size());
    for (int i = 0; i < ef.size() && f0 + i < obs_fetch.size(); i++)
      chk($sformatf("%s_fetch%0d", nm, i), obs_fetch[f0 + i], ef[i]);
    chk({nm, "_nissue"}, n_issue - i0, ei);
    chk({nm, "_excl"}, excl_viol - x0, 0);
    chk({nm, "_res_lat"}, lat_viol - l0, 0);
    if (er.size() > 0) chk({nm, "_hold"}, 32'({o_zero_flag, o_carry, o_result}), 32'(er[er.size() - 1]));
  endtask

  function automatic logic [IS-1:0] ins(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    return {op, a, b, 8'($urandom)};
  endfunction

  initial begin
    int r0, f0, cyc;
    logic [3:0] ops [6];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'h5; ops[5] = 4'hF;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    i_reset = 1; i_start = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {25'd0, o_busy, o_rom_rd_en, o_alu_valid, o_valid_result, o_all_done, o_carry, o_zero_flag}, 32'd0);
    chk("rst_data", {8'd0, o_result, o_alu_a, o_alu_b}, 32'd0);
    chk("rst_addr", {25'd0, o_rom_addr, o_alu_op}, 32'd0);
    i_reset = 0;
    repeat (2) @(negedge clk);
    chk("idle_busy", {30'd0, o_busy, o_all_done}, 32'd0);

    rom[0] = ins(4'h1, 8'd3, 8'd4); rom[1] = ins(4'hF, 8'd0, 8'd0);
    run_prog("add", 0);
    chk("add_val", {22'd0, o_zero_flag, o_carry, o_result}, 32'd7);

    rom[0] = ins(4'h1, 8'd200, 8'd100);
    run_prog("carry", 0);
    chk("carry_val", {22'd0, o_zero_flag, o_carry, o_result}, {22'd0, 2'b01, 8'd44});

    rom[0] = ins(4'h1, 8'd0, 8'd0);
    run_prog("zero", 0);
    chk("zero_val", {22'd0, o_zero_flag, o_carry, o_result}, {22'd0, 2'b10, 8'd0});

    rom[0] = ins(4'h0, 8'd9, 8'd9); rom[1] = ins(4'h1, 8'd1, 8'd1); rom[2] = ins(4'hF, 8'd0, 8'd0);
    run_prog("nop", 0);
    chk("nop_val", 32'(o_result), 32'd2);

    for (int i = 0; i < DEPTH; i++) rom[i] = ins(ops[$urandom_range(1, 4)], 8'($urandom), 8'($urandom));
    run_prog("nohalt", 0);

    spur_en = 1;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = ins(ops[$urandom_range(0, 4)], 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) != 0) rom[$urandom_range(1, DEPTH - 1)] = ins(4'hF, 8'd0, 8'd0);
      run_prog($sformatf("rnd%0d", k), 1);
      run_prog($sformatf("rerun%0d", k), 1);
    end
    spur_en = 0;

    rom[0] = ins(4'h1, 8'd5, 8'd6); rom[1] = ins(4'hF, 8'd0, 8'd0);
    hold_alu = 1;
    r0 = obs_res.size();
    @(negedge clk); i_start = 1;
    @(negedge clk); i_start = 0;
    cyc = 0;
    while (!pend && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rst_reach_alu", {31'd0, pend}, 32'd1);
    @(negedge clk); #2 i_reset = 1;
    #1;
    chk("mid_rst_ctl", {25'd0, o_busy, o_rom_rd_en, o_alu_valid, o_valid_result, o_all_done, o_carry, o_zero_flag}, 32'd0);
    chk("mid_rst_data", {8'd0, o_result, o_alu_a, o_alu_b}, 32'd0);
    @(negedge clk); #2;
    i_reset = 0; hold_alu = 0; force_done = 1;
    f0 = obs_fetch.size();
    @(negedge clk); #2 force_done = 0;
    repeat (10) @(negedge clk);
    chk("late_done_nres", obs_res.size() - r0, 0);
    chk("late_done_state", {29'd0, o_busy, o_all_done, o_valid_result}, 32'd0);
    chk("late_done_fetch", obs_fetch.size() - f0, 0);
    chk("late_done_result", {22'd0, o_zero_flag, o_carry, o_result}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
